// File: rtl/nn_execute_stage.sv
// nn_execute_stage: decode/execute pipeline register plus the two-ALU execute
// datapath (ALU1 on A and B/immediate, ALU2 on the ALU1 result and C).
// Outputs feed data-memory address/data, write-back select, register-file
// write port and PC enable.
module nn_execute_stage #(
  parameter int BUS_WIDTH      = 32,
  parameter int REGISTER       = 6,
  parameter int ALU_FUNCT_BITS = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PCEnD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      MemtoRegD,
  input  logic                      ALUSrcD,
  input  logic                      RegDstD,
  input  logic [ALU_FUNCT_BITS-1:0] ALU1CntrlD,
  input  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlD,
  input  logic [BUS_WIDTH-1:0]      Src1AD,
  input  logic [BUS_WIDTH-1:0]      Src1BD,
  input  logic [BUS_WIDTH-1:0]      Src1CD,
  input  logic [BUS_WIDTH-1:0]      BitFieldImmD,
  input  logic [REGISTER-1:0]       RtD,
  input  logic [REGISTER-1:0]       RdD,
  output logic                      PCEn,
  output logic                      RegWrite,
  output logic                      MemWrite,
  output logic                      MemtoReg,
  output logic [REGISTER-1:0]       WriteDstReg,
  output logic [BUS_WIDTH-1:0]      ALUOut1,
  output logic [BUS_WIDTH-1:0]      ALUOut2,
  output logic [BUS_WIDTH-1:0]      WriteData
);

  // Registered copies of the decode-stage fields.
  logic                      ALUSrc;
  logic                      RegDst;
  logic [ALU_FUNCT_BITS-1:0] ALU1Cntrl;
  logic [ALU_FUNCT_BITS-1:0] ALU2Cntrl;
  logic [BUS_WIDTH-1:0]      Src1A;
  logic [BUS_WIDTH-1:0]      Src1B;
  logic [BUS_WIDTH-1:0]      Src1C;
  logic [BUS_WIDTH-1:0]      BitFieldImm;
  logic [REGISTER-1:0]       Rt;
  logic [REGISTER-1:0]       Rd;

  logic [BUS_WIDTH-1:0]      srcB;

  // Pipeline register: capture every decode field each cycle, cleared by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values, so the order of these statements cannot change behaviour.
      PCEn        <= 1'b0;
      RegWrite    <= 1'b0;
      MemWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      ALUSrc      <= 1'b0;
      RegDst      <= 1'b0;
      ALU1Cntrl   <= '0;
      ALU2Cntrl   <= '0;
      Src1A       <= '0;
      Src1B       <= '0;
      Src1C       <= '0;
      BitFieldImm <= '0;
      Rt          <= '0;
      Rd          <= '0;
    end else begin
      PCEn        <= PCEnD;
      RegWrite    <= RegWriteD;
      MemWrite    <= MemWriteD;
      MemtoReg    <= MemtoRegD;
      ALUSrc      <= ALUSrcD;
      RegDst      <= RegDstD;
      ALU1Cntrl   <= ALU1CntrlD;
      ALU2Cntrl   <= ALU2CntrlD;
      Src1A       <= Src1AD;
      Src1B       <= Src1BD;
      Src1C       <= Src1CD;
      BitFieldImm <= BitFieldImmD;
      Rt          <= RtD;
      Rd          <= RdD;
    end
  end

  // Operand and destination muxes; store data is the raw B operand.
  assign srcB        = ALUSrc ? BitFieldImm : Src1B;
  assign WriteDstReg = RegDst ? Rd : Rt;
  assign WriteData   = Src1B;

  // ALU1: arithmetic/logic on A and the selected B source.
  always_comb begin
    // NOTE: the default assignment up front guarantees a value on every path,
    // so no latch is inferred even if the case list is edited later.
    ALUOut1 = '0;
    case (ALU1Cntrl)
      3'b000:  ALUOut1 = Src1A + srcB;
      3'b001:  ALUOut1 = Src1A - srcB;
      3'b010:  ALUOut1 = Src1A * srcB;
      3'b011:  ALUOut1 = Src1A & srcB;
      3'b100:  ALUOut1 = Src1A | srcB;
      3'b101:  ALUOut1 = Src1A ^ srcB;
      3'b110:  ALUOut1 = ($signed(Src1A) < $signed(srcB)) ? BUS_WIDTH'(1) : '0;
      default: ALUOut1 = Src1A;
    endcase
  end

  // ALU2: neural-network post-ops on the ALU1 result and operand C.
  always_comb begin
    ALUOut2 = '0;
    case (ALU2Cntrl)
      3'b000:  ALUOut2 = ALUOut1;
      3'b001:  ALUOut2 = ALUOut1 + Src1C;
      3'b010:  ALUOut2 = ALUOut1 - Src1C;
      3'b011:  ALUOut2 = ALUOut1[BUS_WIDTH-1] ? '0 : ALUOut1;
      3'b100:  ALUOut2 = ALUOut1 * Src1C;
      3'b101:  ALUOut2 = ($signed(ALUOut1) > $signed(Src1C)) ? ALUOut1 : Src1C;
      3'b110:  ALUOut2 = ($signed(ALUOut1) < $signed(Src1C)) ? ALUOut1 : Src1C;
      default: ALUOut2 = Src1C;
    endcase
  end

endmodule

// File: tb/tb_nn_execute_stage.sv
// tb_nn_execute_stage: directed self-checking bench for nn_execute_stage.
module tb_nn_execute_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCEnD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, RegDstD;
  logic [2:0]  ALU1CntrlD, ALU2CntrlD;
  logic [31:0] Src1AD, Src1BD, Src1CD, BitFieldImmD;
  logic [5:0]  RtD, RdD;
  logic        PCEn, RegWrite, MemWrite, MemtoReg;
  logic [5:0]  WriteDstReg;
  logic [31:0] ALUOut1, ALUOut2, WriteData;

  int checks = 0;
  int errors = 0;

  nn_execute_stage dut (
    .CLK(CLK), .RST(RST),
    .PCEnD(PCEnD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .ALU1CntrlD(ALU1CntrlD), .ALU2CntrlD(ALU2CntrlD),
    .Src1AD(Src1AD), .Src1BD(Src1BD), .Src1CD(Src1CD),
    .BitFieldImmD(BitFieldImmD), .RtD(RtD), .RdD(RdD),
    .PCEn(PCEn), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .WriteDstReg(WriteDstReg), .ALUOut1(ALUOut1), .ALUOut2(ALUOut2),
    .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  // Drive a plain ALU instruction (register B source, control bits low).
  task automatic drive_alu(input logic [2:0] a1, input logic [2:0] a2,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
    PCEnD = 1'b1; RegWriteD = 1'b0; MemWriteD = 1'b0; MemtoRegD = 1'b0;
    ALUSrcD = 1'b0; RegDstD = 1'b0; BitFieldImmD = 32'h0;
    RtD = 6'd0; RdD = 6'd0;
    ALU1CntrlD = a1; ALU2CntrlD = a2;
    Src1AD = a; Src1BD = b; Src1CD = c;
  endtask

  // Advance to the capture edge, then sample just after it.
  task automatic capture();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    PCEnD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1;
    ALUSrcD = 1'b0; RegDstD = 1'b1;
    ALU1CntrlD = 3'b001; ALU2CntrlD = 3'b001;
    Src1AD = 32'd5; Src1BD = 32'd3; Src1CD = 32'd4; BitFieldImmD = 32'h55;
    RtD = 6'd6; RdD = 6'd7;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({PCEn, RegWrite, MemWrite, MemtoReg} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {PCEn, RegWrite, MemWrite, MemtoReg});
    end
    checks++;
    if (ALUOut1 !== 32'h0 || ALUOut2 !== 32'h0 || WriteData !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", ALUOut1, ALUOut2, WriteData);
    end
    checks++;
    if (WriteDstReg !== 6'd0) begin
      errors++; $display("FAIL reset_dst: got %0d expected 0", WriteDstReg);
    end
    // Release and capture the waiting D inputs: SUB 5-3=2, then +4 = 6.
    @(negedge CLK);
    RST = 1'b0;
    capture();
    checks++;
    if ({PCEn, RegWrite, MemWrite, MemtoReg} !== 4'b1111) begin
      errors++; $display("FAIL release_ctrl: got %b expected 1111", {PCEn, RegWrite, MemWrite, MemtoReg});
    end
    checks++;
    if (ALUOut1 !== 32'd2 || ALUOut2 !== 32'd6 || WriteData !== 32'd3 || WriteDstReg !== 6'd7) begin
      errors++; $display("FAIL release_data: got %h/%h/%h/%0d expected 2/6/3/7", ALUOut1, ALUOut2, WriteData, WriteDstReg);
    end
    // Mid-cycle assertion must clear the registers without waiting for CLK.
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({PCEn, RegWrite, MemWrite} !== 3'b000 || ALUOut2 !== 32'h0) begin
      errors++; $display("FAIL async_reset: got %b/%h expected 000/0", {PCEn, RegWrite, MemWrite}, ALUOut2);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_mac();
    @(negedge CLK);
    drive_alu(3'b010, 3'b001, 32'd3, 32'd4, 32'd10);
    capture();
    checks++;
    if (ALUOut1 !== 32'd12 || ALUOut2 !== 32'd22) begin
      errors++; $display("FAIL mac: got %0d/%0d expected 12/22", ALUOut1, ALUOut2);
    end
  endtask

  task automatic test_relu();
    @(negedge CLK);
    drive_alu(3'b001, 3'b011, 32'd5, 32'd9, 32'd0);
    capture();
    checks++;
    if (ALUOut1 !== 32'hFFFF_FFFC || ALUOut2 !== 32'h0) begin
      errors++; $display("FAIL relu_neg: got %h/%h expected fffffffc/0", ALUOut1, ALUOut2);
    end
    @(negedge CLK);
    drive_alu(3'b001, 3'b011, 32'd9, 32'd5, 32'd0);
    capture();
    checks++;
    if (ALUOut2 !== 32'd4) begin
      errors++; $display("FAIL relu_pos: got %h expected 4", ALUOut2);
    end
  endtask

  task automatic test_load_store();
    @(negedge CLK);
    drive_alu(3'b000, 3'b000, 32'h100, 32'hDEAD, 32'h7);
    ALUSrcD = 1'b1; BitFieldImmD = 32'h20; MemWriteD = 1'b1;
    capture();
    checks++;
    if (ALUOut2 !== 32'h120 || WriteData !== 32'hDEAD || MemWrite !== 1'b1) begin
      errors++; $display("FAIL store: got %h/%h/%b expected 120/dead/1", ALUOut2, WriteData, MemWrite);
    end
    @(negedge CLK);
    MemWriteD = 1'b0; MemtoRegD = 1'b1;
    capture();
    checks++;
    if (MemWrite !== 1'b0 || MemtoReg !== 1'b1 || ALUOut2 !== 32'h120) begin
      errors++; $display("FAIL load: got %b/%b/%h expected 0/1/120", MemWrite, MemtoReg, ALUOut2);
    end
  endtask

  task automatic test_dest_wrap();
    @(negedge CLK);
    drive_alu(3'b000, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    RtD = 6'd5; RdD = 6'd9; RegDstD = 1'b0;
    capture();
    checks++;
    if (WriteDstReg !== 6'd5) begin
      errors++; $display("FAIL dst_rt: got %0d expected 5", WriteDstReg);
    end
    checks++;
    if (ALUOut1 !== 32'h0) begin
      errors++; $display("FAIL add_wrap: got %h expected 0", ALUOut1);
    end
    @(negedge CLK);
    RegDstD = 1'b1;
    capture();
    checks++;
    if (WriteDstReg !== 6'd9) begin
      errors++; $display("FAIL dst_rd: got %0d expected 9", WriteDstReg);
    end
  endtask

  typedef struct {
    logic [2:0]  a1, a2;
    logic [31:0] a, b, c, exp1, exp2;
  } vec_t;

  task automatic test_back_to_back();
    vec_t v[11];
    v[0]  = '{3'b000, 3'b000, 32'd7,          32'd5,          32'd0,          32'd12,         32'd12};
    v[1]  = '{3'b001, 3'b001, 32'd20,         32'd8,          32'd3,          32'd12,         32'd15};
    v[2]  = '{3'b010, 3'b010, 32'd6,          32'd7,          32'd50,         32'd42,         32'hFFFF_FFF8};
    v[3]  = '{3'b011, 3'b011, 32'hF0F0,       32'hFF00,       32'd0,          32'hF000,       32'hF000};
    v[4]  = '{3'b100, 3'b100, 32'h0F,         32'hF0,         32'd2,          32'hFF,         32'h1FE};
    v[5]  = '{3'b101, 3'b101, 32'hFF,         32'h0F,         32'hFFFF_FFFF,  32'hF0,         32'hF0};
    v[6]  = '{3'b110, 3'b110, 32'hFFFF_FFFE,  32'd1,          32'h8000_0000,  32'd1,          32'h8000_0000};
    v[7]  = '{3'b111, 3'b111, 32'h1234,       32'h99,         32'hABCD,       32'h1234,       32'hABCD};
    v[8]  = '{3'b110, 3'b011, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0,          32'd0};
    v[9]  = '{3'b111, 3'b101, 32'hFFFF_FFF0,  32'd0,          32'd3,          32'hFFFF_FFF0,  32'd3};
    v[10] = '{3'b010, 3'b000, 32'h1_0000,     32'h1_0000,     32'd0,          32'd0,          32'd0};
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      drive_alu(v[i].a1, v[i].a2, v[i].a, v[i].b, v[i].c);
      capture();
      checks++;
      if (ALUOut1 !== v[i].exp1 || ALUOut2 !== v[i].exp2 || WriteData !== v[i].b) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%h/%h expected %h/%h/%h",
                 i, ALUOut1, ALUOut2, WriteData, v[i].exp1, v[i].exp2, v[i].b);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    drive_alu(3'b000, 3'b000, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_mac();
    test_relu();
    test_load_store();
    test_dest_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_execute_stage.md
# nn_execute_stage

Decode/execute pipeline boundary and execute datapath of the 3-stage neural-network processor. It captures decoded control and operands on each clock edge, then computes a two-ALU chain: ALU1 on A and B/immediate, and ALU2 on the ALU1 result and operand C. Its outputs drive the data-memory address and write data, the write-back mux select, the register-file write port, and PC enable.

## Interface
- BUS_WIDTH, 32, datapath width
- REGISTER, 6, register-address width
- ALU_FUNCT_BITS, 3, ALU control width
- CLK  in  1  sole clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- PCEnD, RegWriteD, MemWriteD, MemtoRegD  in  1 each  decode-stage control bits, forwarded unchanged
- ALUSrcD  in  1  ALU1 B-source select (0 = B operand, 1 = immediate)
- RegDstD  in  1  destination select (0 = Rt, 1 = Rd)
- ALU1CntrlD, ALU2CntrlD  in  3 each  ALU opcodes
- Src1AD, Src1BD, Src1CD  in  32 each  register operands A, B, C
- BitFieldImmD  in  32  extended immediate
- RtD, RdD  in  6 each  candidate destination registers
- PCEn, RegWrite, MemWrite, MemtoReg  out  1 each  registered copies of the decode-stage bits
- WriteDstReg  out  6  selected destination register
- ALUOut1  out  32  ALU1 result
- ALUOut2  out  32  ALU2 result; also the data-memory address
- WriteData  out  32  registered B operand, used as store data

## Operation
- Pipeline register: every D input is captured into a same-named register with the D suffix dropped. No enable, stall or flush.
- Operand select: SrcB = ALUSrc ? BitFieldImm : Src1B.
- Destination select: WriteDstReg = RegDst ? Rd : Rt.
- WriteData = Src1B (registered B operand, not the muxed SrcB).
- ALU1 (A = Src1A, B = SrcB):
  - 000 A+B
  - 001 A−B
  - 010 A×B, low 32 bits
  - 011 A&B
  - 100 A|B
  - 101 A^B
  - 110 signed A<B ? 1 : 0
  - 111 pass A
- ALU2 (R = ALUOut1, C = Src1C):
  - 000 pass R
  - 001 R+C (MAC accumulate)
  - 010 R−C
  - 011 ReLU: R if R ≥ 0 signed, else 0
  - 100 R×C, low 32 bits
  - 101 signed max(R,C)
  - 110 signed min(R,C)
  - 111 pass C
- Arithmetic: two's complement; add, subtract and multiply wrap modulo 2^32; no flags or exceptions.
- Loads and stores use ALU1=000 with ALUSrc=1 and ALU2=000, so ALUOut2 = A + imm.

## Timing
- Reset (asynchronous, active-high): all pipeline registers clear to 0 immediately, independent of CLK. While RST is high, every registered output is 0, ALUOut1 = ALUOut2 = 0 (ADD of zeros), and WriteDstReg = 0.
- Reset release: the first rising edge after RST deasserts captures the D inputs normally.
- Latency: D inputs appear on the registered outputs one cycle later. ALUOut1, ALUOut2 and WriteDstReg settle combinationally within that same cycle.
- Throughput: one instruction per cycle, no bubbles inserted.
- No forwarding or hazard detection; a result is visible to a later instruction only via register-file write-back.
- RST asserted mid-stream discards the in-flight instruction; PCEn, RegWrite and MemWrite drop to 0 at once.

## Test plan
- Reset: drive all D inputs nonzero with RST=1 -> every output is 0; after release and one edge, outputs reflect the D inputs.
- MAC: A=3, B=4, C=10, ALU1=010, ALU2=001, ALUSrc=0 -> ALUOut1=12, ALUOut2=22, one cycle after capture.
- ReLU: A=5, B=9, ALU1=001, ALU2=011 -> ALUOut1=0xFFFFFFFC, ALUOut2=0. With A=9, B=5 -> ALUOut2=4.
- Load/store address: A=0x100, imm=0x20, ALUSrc=1, ALU1=000, ALU2=000, Src1BD=0xDEAD -> ALUOut2=0x120, WriteData=0xDEAD, MemWrite follows MemWriteD.
- Destination/wrap: RtD=5, RdD=9, RegDst toggling -> WriteDstReg 5 then 9. A=0xFFFFFFFF, B=1, ADD -> ALUOut1=0.
- Back-to-back: new operands every cycle with all ALU1 and ALU2 codes -> each result matches its own instruction one cycle later.
